// File: rtl/muldiv_seq_pkg.sv
// Shared widths, op/state encodings and operand helper for the muldiv_seq sequencer.
package muldiv_seq_pkg;

    localparam int DP_WIDTH = 32;
    localparam int CNT_W    = 5;

    typedef enum logic [1:0] {
        MULDIV_MULT  = 2'b00,
        MULDIV_MULTU = 2'b01,
        MULDIV_DIV   = 2'b10,
        MULDIV_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_e;

    // For signed ops, return |v|; the most negative value maps to itself, read as unsigned.
    function automatic logic [DP_WIDTH-1:0] magnitude(input logic [DP_WIDTH-1:0] v,
                                                      input logic                is_signed);
        return (is_signed && v[DP_WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide around a single 32-bit adder.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step
    import muldiv_seq_pkg::*;
(
`ifdef MULDIV_DIV_EN
    input  logic                div_mode,
`endif
    input  logic [DP_WIDTH-1:0] hi_in,
    input  logic [DP_WIDTH-1:0] lo_in,
    input  logic [DP_WIDTH-1:0] opnd,
    output logic [DP_WIDTH-1:0] hi_out,
    output logic [DP_WIDTH-1:0] lo_out
);

    logic [DP_WIDTH-1:0] add_x;
    logic [DP_WIDTH-1:0] add_y;
    logic                add_cin;
    logic [DP_WIDTH:0]   sum;
`ifdef MULDIV_DIV_EN
    logic                take;
`endif

    always_comb begin
        add_x   = hi_in;
        add_y   = lo_in[0] ? opnd : '0;
        add_cin = 1'b0;
`ifdef MULDIV_DIV_EN
        take    = 1'b0;
        if (div_mode) begin
            add_x   = {hi_in[DP_WIDTH-2:0], lo_in[DP_WIDTH-1]};
            add_y   = ~opnd;
            add_cin = 1'b1;
        end
`endif
        sum = {1'b0, add_x} + {1'b0, add_y} + {{DP_WIDTH{1'b0}}, add_cin};

        // Multiply: shift {carry, sum, multiplier} right by one.
        hi_out = {sum[DP_WIDTH], sum[DP_WIDTH-1:1]};
        lo_out = {sum[0], lo_in[DP_WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        // Divide: the bit shifted out of hi_in is the 33rd remainder bit, so it forces the subtract.
        if (div_mode) begin
            take   = hi_in[DP_WIDTH-1] | sum[DP_WIDTH];
            hi_out = take ? sum[DP_WIDTH-1:0] : add_x;
            lo_out = {lo_in[DP_WIDTH-2:0], take};
        end
`endif
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MIPS mult/multu/div/divu sequencer writing architectural HI/LO.
// Define MULDIV_DIV_EN to compile in divide support; otherwise div/divu return err.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [DP_WIDTH-1:0] a,
    input  logic [DP_WIDTH-1:0] b,
    input  logic                flush,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DP_WIDTH-1:0] hi,
    output logic [DP_WIDTH-1:0] lo
);

    muldiv_state_e       state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DP_WIDTH-1:0] acc_q, acc_d;
    logic [DP_WIDTH-1:0] low_q, low_d;
    logic [DP_WIDTH-1:0] opnd_q, opnd_d;
    logic                neg_p_q, neg_p_d;
    logic                err_q, err_d;
    logic [DP_WIDTH-1:0] hi_q, hi_d;
    logic [DP_WIDTH-1:0] lo_q, lo_d;
`ifdef MULDIV_DIV_EN
    logic                is_div_q, is_div_d;
    logic                neg_r_q, neg_r_d;
    logic [DP_WIDTH-1:0] quot_fix;
    logic [DP_WIDTH-1:0] rem_fix;
`endif

    logic                  signed_op;
    logic [DP_WIDTH-1:0]   a_mag;
    logic [DP_WIDTH-1:0]   b_mag;
    logic [2*DP_WIDTH-1:0] prod_fix;
    logic [DP_WIDTH-1:0]   step_hi;
    logic [DP_WIDTH-1:0]   step_lo;

    muldiv_step u_step (
`ifdef MULDIV_DIV_EN
        .div_mode (is_div_q),
`endif
        .hi_in    (acc_q),
        .lo_in    (low_q),
        .opnd     (opnd_q),
        .hi_out   (step_hi),
        .lo_out   (step_lo)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        low_d   = low_q;
        opnd_d  = opnd_q;
        neg_p_d = neg_p_q;
        err_d   = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
        is_div_d = is_div_q;
        neg_r_d  = neg_r_q;
        quot_fix = neg_p_q ? -low_q : low_q;
        rem_fix  = neg_r_q ? -acc_q : acc_q;
`endif
        signed_op = (op == MULDIV_MULT) || (op == MULDIV_DIV);
        a_mag     = magnitude(a, signed_op);
        b_mag     = magnitude(b, signed_op);
        prod_fix  = neg_p_q ? -{acc_q, low_q} : {acc_q, low_q};

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start && !flush) begin
                    neg_p_d = signed_op && (a[DP_WIDTH-1] ^ b[DP_WIDTH-1]);
                    if (op[1]) begin
`ifdef MULDIV_DIV_EN
                        if (b == '0) begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                            hi_d    = a;
                            lo_d    = '1;
                        end else begin
                            state_d  = S_CALC;
                            cnt_d    = '1;
                            acc_d    = '0;
                            low_d    = a_mag;
                            opnd_d   = b_mag;
                            neg_r_d  = signed_op && a[DP_WIDTH-1];
                            is_div_d = 1'b1;
                        end
`else
                        state_d = S_DONE;
                        err_d   = 1'b1;
`endif
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = '1;
                        acc_d   = '0;
                        low_d   = b_mag;
                        opnd_d  = a_mag;
`ifdef MULDIV_DIV_EN
                        is_div_d = 1'b0;
`endif
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_hi;
                    low_d = step_lo;
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
`else
                    {hi_d, lo_d} = prod_fix;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset too, since hi/lo must read zero after any reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            low_q    <= '0;
            opnd_q   <= '0;
            neg_p_q  <= 1'b0;
            err_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
            neg_r_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            low_q    <= low_d;
            opnd_q   <= opnd_d;
            neg_p_q  <= neg_p_d;
            err_q    <= err_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MULDIV_DIV_EN
            is_div_q <= is_div_d;
            neg_r_q  <= neg_r_d;
`endif
        end
    end

    assign busy = (state_q == S_CALC) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);
    assign err  = err_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: arithmetic reference model, directed and random ops.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o, done_o, err_o;
    logic [31:0] hi_o, lo_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
        int          lat;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;

    muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_i),
        .op    (op_i),
        .a     (a_i),
        .b     (b_i),
        .flush (flush_i),
        .busy  (busy_o),
        .done  (done_o),
        .err   (err_o),
        .hi    (hi_o),
        .lo    (lo_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output exp_t e);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        e.err = 1'b0;
        e.lat = 34;
        e.due = 0;
        case (o)
            2'b00: begin p = 64'(sx * sy); e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = {32'b0, x} * {32'b0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (y == 0) begin
                    e.hi = x; e.lo = 32'hFFFF_FFFF; e.err = 1'b1; e.lat = 1;
                end else if (o == 2'b10) begin
                    q = sx / sy; r = sx % sy;
                    e.hi = r[31:0]; e.lo = q[31:0];
                end else begin
                    e.hi = x % y; e.lo = x / y;
                end
`else
                e.hi = mdl_hi; e.lo = mdl_lo; e.err = 1'b1; e.lat = 1;
`endif
            end
        endcase
        mdl_hi = e.hi;
        mdl_lo = e.lo;
    endtask

    // Scoreboard monitor: each done pops one expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done_o) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 64'(done_o), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("hi", 64'(hi_o), 64'(e.hi));
                check("lo", 64'(lo_o), 64'(e.lo));
                check("err", 64'(err_o), 64'(e.err));
                check("done_cycle", 64'(cyc), 64'(e.due));
            end
        end else if (err_o) begin
            check("err_without_done", 64'(err_o), 64'd0);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) check("idle_timeout", 64'(busy_o), 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("done_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int c0);
        exp_t e;
        wait_idle();
        model(o, x, y, e);
        op_i = o; a_i = x; b_i = y; start_i = 1'b1;
        c0    = cyc;
        e.due = cyc + e.lat;
        sb_q.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
        a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin : stimulus
        int          c0;
        logic [31:0] saved_hi, saved_lo, x, y;
        exp_t        dummy;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);

        // multu worst case with busy window checks
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c0);
        check("busy_cycle1", 64'(busy_o), 64'd1);
        wait_cycle(c0 + 33);
        check("busy_cycle33", 64'(busy_o), 64'd1);
        wait_cycle(c0 + 34);
        check("busy_cycle34", 64'(busy_o), 64'd0);
        drain();

        run_op(2'b00, 32'hFFFF_FFF9, 32'd3, c0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, c0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, c0);
        run_op(2'b11, 32'h0000_1234, 32'd0, c0);
        run_op(2'b10, 32'h0000_0064, 32'hFFFF_FFF9, c0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, c0);
        drain();

        // start pulsed in cycle 5 must be ignored
        run_op(2'b00, 32'h0001_2345, 32'hFFFF_0003, c0);
        wait_cycle(c0 + 5);
        op_i = 2'b01; a_i = 32'hDEAD_BEEF; b_i = 32'h0000_0000; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        drain();

        // flush in cycle 10: no done, hi/lo held, then a normal op
        saved_hi = mdl_hi; saved_lo = mdl_lo;
        run_op(2'b01, 32'h1357_9BDF, 32'h0246_8ACE, c0);
        wait_cycle(c0 + 10);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_busy", 64'(busy_o), 64'd0);
        check("flush_hi", 64'(hi_o), 64'(saved_hi));
        check("flush_lo", 64'(lo_o), 64'(saved_lo));
        void'(sb_q.pop_back());
        mdl_hi = saved_hi; mdl_lo = saved_lo;
        repeat (2) @(negedge clk);
        run_op(2'b01, 32'h0000_FFFF, 32'h0001_0001, c0);
        drain();

        // flush together with start in IDLE starts nothing
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; a_i = 32'd5; b_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        check("flush_start_busy", 64'(busy_o), 64'd0);
        check("flush_start_done", 64'(done_o), 64'd0);

        // random ops; wait_idle returns in the DONE cycle, so many starts are back-to-back
        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: x = 32'h8000_0000;
                3: y = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(2'($urandom), x, y, c0);
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        drain();

        // synchronous reset in cycle 20 of an op
        run_op(2'b01, 32'hCAFE_F00D, 32'h1234_5678, c0);
        wait_cycle(c0 + 20);
        rst_n = 1'b0;
        @(negedge clk);
        sb_q.delete();
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_done", 64'(done_o), 64'd0);
        check("midrst_err", 64'(err_o), 64'd0);
        check("midrst_hi", 64'(hi_o), 64'd0);
        check("midrst_lo", 64'(lo_o), 64'd0);
        mdl_hi = '0; mdl_lo = '0;
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c0);
        drain();
        model(2'b00, 32'd0, 32'd0, dummy);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
